// File: rtl/cdac_load_arb.sv
// rtl/cdac_load_arb.sv - round-robin arbiter and 16-bit serial frame driver for the comparator-threshold DAC
// Optional: CDAC_SKIP_DUP_EN skips the frame when the granted value equals the last loaded value.
module cdac_load_arb #(
    parameter int NREQ = 3,
    parameter int DIV  = 20,
    parameter int GAP  = 2
) (
    input  logic               CLK40,
    input  logic               RST_B,
    input  logic [NREQ-1:0]    REQ,
    input  logic [12*NREQ-1:0] DATA,
    output logic [NREQ-1:0]    ACK,
    output logic               BUSY,
    output logic               SCLK,
    output logic               SDATA,
    output logic               DAC_ENB,
    output logic [11:0]        LAST_VAL,
    output logic [2:0]         LAST_SRC,
    output logic [7:0]         LOAD_CNT
);
    localparam int IW      = $clog2(NREQ);
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GAP_CYC = 2 * GAP * DIV;
    localparam int GW      = $clog2(GAP_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IW-1:0]     r_gnt_idx;
    logic [IW-1:0]     r_src;
    logic [IW-1:0]     r_ptr;
    logic              r_mask_vld;
    logic [15:0]       r_shreg;
    logic [11:0]       r_val;
    logic [DW-1:0]     r_div_cnt;
    logic [3:0]        r_bit_cnt;
    logic [GW-1:0]     r_gap_cnt;
    logic              r_sclk;
    logic              r_enb;
    logic [11:0]       r_last_val;
    logic [2:0]        r_last_src;
    logic [7:0]        r_load_cnt;

    logic              w_pick_vld;
    logic [IW-1:0]     w_pick_idx;
    logic [11:0]       w_gnt_data;
    logic              w_div_wrap;
    logic              w_fall;
    logic              w_last_fall;
    logic              w_gap_end;
    logic              w_skip;
    logic [NREQ-1:0]   w_ack;

`ifdef CDAC_SKIP_DUP_EN
    logic              r_last_valid;
    logic              r_skip;
    assign w_skip = r_last_valid && (w_gnt_data == r_last_val);
`else
    assign w_skip = 1'b0;
`endif

    // Search starts just after the pointer; the index acked last is hidden for one IDLE cycle
    always_comb begin
        int cand;
        cand       = 0;
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(r_ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!w_pick_vld && (i == cand) && REQ[i] &&
                    !(r_mask_vld && (r_src == IW'(i)))) begin
                    w_pick_vld = 1'b1;
                    w_pick_idx = IW'(i);
                end
            end
        end
    end

    always_comb begin
        w_gnt_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt_idx == IW'(i)) begin
                w_gnt_data = DATA[12*i +: 12];
            end
        end
    end

    always_comb begin
        w_ack = '0;
        for (int i = 0; i < NREQ; i++) begin
            if ((r_state == S_DONE) && (r_src == IW'(i))) begin
                w_ack[i] = 1'b1;
            end
        end
    end

    assign w_div_wrap  = (r_div_cnt == DW'(DIV - 1));
    assign w_fall      = w_div_wrap && r_sclk;
    assign w_last_fall = w_fall && (r_bit_cnt == 4'd15);
    assign w_gap_end   = (r_gap_cnt == GW'(GAP_CYC - 1));

    always_ff @(posedge CLK40) begin
        if (!RST_B) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                w_state_nxt = w_skip ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                if (w_last_fall) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK40) begin
        if (!RST_B) begin
            r_gnt_idx    <= '0;
            r_src        <= '0;
            r_ptr        <= IW'(NREQ - 1);
            r_mask_vld   <= 1'b0;
            r_shreg      <= '0;
            r_val        <= '0;
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_sclk       <= 1'b0;
            r_enb        <= 1'b0;
            r_last_val   <= '0;
            r_last_src   <= '0;
            r_load_cnt   <= '0;
`ifdef CDAC_SKIP_DUP_EN
            r_last_valid <= 1'b0;
            r_skip       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_mask_vld <= 1'b0;
                    if (w_pick_vld) begin
                        r_gnt_idx <= w_pick_idx;
                    end
                end
                S_GRANT: begin
                    r_src     <= r_gnt_idx;
                    r_ptr     <= r_gnt_idx;
                    r_val     <= w_gnt_data;
                    r_div_cnt <= '0;
                    r_bit_cnt <= '0;
                    r_sclk    <= 1'b0;
`ifdef CDAC_SKIP_DUP_EN
                    r_skip    <= w_skip;
`endif
                    if (!w_skip) begin
                        r_shreg <= {3'b000, w_gnt_data, 1'b0};
                        r_enb   <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
                    if (w_div_wrap) begin
                        r_sclk <= ~r_sclk;
                    end
                    // Data moves only on the falling toggle so it is settled at every rise
                    if (w_fall) begin
                        r_shreg   <= {r_shreg[14:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    if (w_last_fall) begin
                        r_enb     <= 1'b0;
                        r_gap_cnt <= '0;
                    end
                end
                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt + 1'b1;
                end
                S_DONE: begin
                    r_last_val <= r_val;
                    r_last_src <= 3'(r_src);
                    r_mask_vld <= 1'b1;
`ifdef CDAC_SKIP_DUP_EN
                    if (!r_skip) begin
                        r_load_cnt   <= r_load_cnt + 1'b1;
                        r_last_valid <= 1'b1;
                    end
`else
                    r_load_cnt <= r_load_cnt + 1'b1;
`endif
                end
                default: begin
                    r_mask_vld <= 1'b0;
                end
            endcase
        end
    end

    assign ACK      = w_ack;
    assign BUSY     = (r_state != S_IDLE);
    assign SCLK     = r_sclk;
    assign SDATA    = r_shreg[15];
    assign DAC_ENB  = r_enb;
    assign LAST_VAL = r_last_val;
    assign LAST_SRC = r_last_src;
    assign LOAD_CNT = r_load_cnt;

endmodule

// File: tb/tb_cdac_load_arb.sv
// tb/tb_cdac_load_arb.sv - directed table-driven bench for cdac_load_arb
module tb_cdac_load_arb;
    logic        clk = 1'b0;
    logic        rst_b;
    logic [2:0]  req;
    logic [35:0] data;
    logic [2:0]  ack;
    logic        busy, sclk, sdata, enb;
    logic [11:0] last_val;
    logic [2:0]  last_src;
    logic [7:0]  load_cnt;

    logic [2:0]  f_req;
    logic [35:0] f_data;
    logic [2:0]  f_ack;
    logic        f_busy, f_sclk, f_sdata, f_enb;
    logic [11:0] f_last_val;
    logic [2:0]  f_last_src;
    logic [7:0]  f_load_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    cdac_load_arb #(.NREQ(3), .DIV(20), .GAP(2)) u_dut (
        .CLK40(clk), .RST_B(rst_b), .REQ(req), .DATA(data), .ACK(ack), .BUSY(busy),
        .SCLK(sclk), .SDATA(sdata), .DAC_ENB(enb), .LAST_VAL(last_val),
        .LAST_SRC(last_src), .LOAD_CNT(load_cnt)
    );

    cdac_load_arb #(.NREQ(3), .DIV(2), .GAP(1)) u_dut_fast (
        .CLK40(clk), .RST_B(rst_b), .REQ(f_req), .DATA(f_data), .ACK(f_ack), .BUSY(f_busy),
        .SCLK(f_sclk), .SDATA(f_sdata), .DAC_ENB(f_enb), .LAST_VAL(f_last_val),
        .LAST_SRC(f_last_src), .LOAD_CNT(f_load_cnt)
    );

    typedef struct packed {
        logic [2:0]  idx;
        logic [11:0] d;
        logic        chg;
        logic [11:0] d2;
        logic [15:0] frame;
        logic [4:0]  rises;
        logic [11:0] enb;
        logic [11:0] lat;
        logic        inc;
    } vec_t;

    vec_t vt [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge two cycles after the ACK
    task automatic load_check(input vec_t v, input int k);
        int          idx, n, rises, enb_cnt, lat;
        logic        prev;
        logic [15:0] frame;
        logic [2:0]  ackv;
        idx = int'(v.idx);
        req[idx] = 1'b1;
        data[12*idx +: 12] = v.d;
        @(posedge clk);
        n = 0; rises = 0; enb_cnt = 0; lat = -1; frame = '0; ackv = '0; prev = 1'b0;
        while (lat < 0 && n < 2000) begin
            @(negedge clk);
            n++;
            if (v.chg && n == 300) data[12*idx +: 12] = v.d2;
            if (sclk && !prev) begin
                frame = {frame[14:0], sdata};
                rises++;
            end
            prev = sclk;
            if (enb) enb_cnt++;
            if (ack != 3'b000) begin
                lat = n;
                ackv = ack;
                req[idx] = 1'b0;
            end
        end
        if (v.inc) exp_cnt = (exp_cnt + 1) % 256;
        check($sformatf("v%0d_latency", k), lat, 32'(v.lat));
        check($sformatf("v%0d_ack", k), ackv, 3'b001 << idx);
        check($sformatf("v%0d_frame", k), frame, v.frame);
        check($sformatf("v%0d_rises", k), rises, 32'(v.rises));
        check($sformatf("v%0d_enb_cycles", k), enb_cnt, 32'(v.enb));
        @(negedge clk);
        check($sformatf("v%0d_ack_one_cycle", k), ack, 3'b000);
        check($sformatf("v%0d_last_val", k), last_val, v.d);
        check($sformatf("v%0d_last_src", k), last_src, idx);
        check($sformatf("v%0d_load_cnt", k), load_cnt, exp_cnt);
        @(negedge clk);
    endtask

    initial begin
        int   n, num, raise_at, falls, acks, last;
        int   order [5];
        int   exp_order [5];
        logic prev;

        vt[0] = '{3'd0, 12'hABC, 1'b0, 12'h000, 16'h1578, 5'd16, 12'd640, 12'd722, 1'b1};
        vt[1] = '{3'd2, 12'h0F0, 1'b1, 12'hFFF, 16'h01E0, 5'd16, 12'd640, 12'd722, 1'b1};
        vt[2] = '{3'd1, 12'h7FF, 1'b0, 12'h000, 16'h0FFE, 5'd16, 12'd640, 12'd722, 1'b1};
`ifdef CDAC_SKIP_DUP_EN
        vt[3] = '{3'd1, 12'h7FF, 1'b0, 12'h000, 16'h0000, 5'd0,  12'd0,   12'd2,   1'b0};
`else
        vt[3] = '{3'd1, 12'h7FF, 1'b0, 12'h000, 16'h0FFE, 5'd16, 12'd640, 12'd722, 1'b1};
`endif
        vt[4] = '{3'd0, 12'h000, 1'b0, 12'h000, 16'h0000, 5'd16, 12'd640, 12'd722, 1'b1};
        vt[5] = '{3'd2, 12'hFFF, 1'b0, 12'h000, 16'h1FFE, 5'd16, 12'd640, 12'd722, 1'b1};
        exp_order = '{0, 1, 2, 0, 1};

        rst_b = 1'b0; req = '0; data = '0; f_req = '0; f_data = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_sclk", sclk, 0);
        check("rst_sdata", sdata, 0);
        check("rst_enb", enb, 0);
        check("rst_last_val", last_val, 0);
        check("rst_last_src", last_src, 0);
        check("rst_load_cnt", load_cnt, 0);
        check("rst_fast_busy", f_busy, 0);
        check("rst_fast_load_cnt", f_load_cnt, 0);
        rst_b = 1'b1;

        for (int k = 0; k < 6; k++) begin
            load_check(vt[k], k);
        end

        // Three simultaneous requests, then two more raised while the third is served
        req = 3'b111;
        data = {12'h111, 12'h222, 12'h333};
        order = '{7, 7, 7, 7, 7};
        n = 0; num = 0; raise_at = -1;
        while (num < 5 && n < 6000) begin
            @(negedge clk);
            n++;
            if (ack != 3'b000) begin
                check("rr_ack_onehot", 32'($onehot(ack)), 1);
                for (int i = 0; i < 3; i++) begin
                    if (ack[i]) begin
                        order[num] = i;
                        req[i] = 1'b0;
                    end
                end
                num++;
                if (num == 2) raise_at = n + 10;
            end
            if (n == raise_at) begin
                check("rr_busy_at_raise", busy, 1);
                req[0] = 1'b1;
                req[1] = 1'b1;
            end
        end
        check("rr_num_acks", num, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_order%0d", i), order[i], exp_order[i]);
        end
        exp_cnt = (exp_cnt + 5) % 256;
        @(negedge clk);
        check("rr_load_cnt", load_cnt, exp_cnt);
        @(negedge clk);

        // Reset at the 7th falling SCLK edge with REQ0 held
        req[0] = 1'b1;
        data[11:0] = 12'h555;
        n = 0; falls = 0; prev = sclk;
        while (falls < 7 && n < 2000) begin
            @(negedge clk);
            n++;
            if (prev && !sclk) falls++;
            prev = sclk;
        end
        check("abort_falls", falls, 7);
        rst_b = 1'b0;
        @(negedge clk);
        check("abort_sclk", sclk, 0);
        check("abort_sdata", sdata, 0);
        check("abort_enb", enb, 0);
        check("abort_busy", busy, 0);
        check("abort_ack", ack, 0);
        check("abort_load_cnt", load_cnt, 0);
        exp_cnt = 0;
        rst_b = 1'b1;
        load_check('{3'd0, 12'h555, 1'b0, 12'h000, 16'h0AAA, 5'd16, 12'd640, 12'd722, 1'b1}, 6);

        // 257 back-to-back loads from REQ1 on the DIV=2, GAP=1 instance
        f_req = 3'b010;
        f_data[23:12] = 12'h001;
        n = 0; acks = 0; last = -1;
        while (acks < 257 && n < 20000) begin
            @(negedge clk);
            n++;
            if (f_ack != 3'b000) begin
                check("wrap_ack", f_ack, 3'b010);
                if (last >= 0) check("wrap_period", n - last, 72);
                last = n;
                acks++;
                f_data[23:12] = 12'(acks + 1);
                if (acks == 257) f_req = '0;
            end
        end
        @(negedge clk);
        check("wrap_num_acks", acks, 257);
        check("wrap_load_cnt", f_load_cnt, 1);
        check("wrap_last_val", f_last_val, 12'h101);
        check("wrap_last_src", f_last_src, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
